// File: rtl/shift_pkg.sv
// Shared encodings for the iterative ARM shifter.
// Shift types, FSM states and a constant log2 helper.
package shift_pkg;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Bits needed to hold values 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP positions.
// Ports: val_i/k_i/sh_i/carry_i in; val_o/carry_o out.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   parameter int KW    = 3
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic [KW-1:0]    k_i,
   input  logic [1:0]       sh_i,
   input  logic             carry_i,
   output logic [WIDTH-1:0] val_o,
   output logic             carry_o
);

   int kk;
   logic [WIDTH-1:0] pre_l;
   logic [WIDTH-1:0] pre_r;

   always_comb begin
      kk      = int'(k_i);
      val_o   = val_i;
      carry_o = carry_i;
      pre_l   = '0;
      pre_r   = '0;
      if (kk != 0) begin
         // Shift by k-1 first so the last bit out lands at a fixed index.
         pre_l = val_i << (kk - 1);
         pre_r = val_i >> (kk - 1);
         case (sh_i)
            SH_LSL: begin
               val_o   = val_i << kk;
               carry_o = pre_l[WIDTH-1];
            end
            SH_LSR: begin
               val_o   = val_i >> kk;
               carry_o = pre_r[0];
            end
            SH_ASR: begin
               val_o   = $signed(val_i) >>> kk;
               carry_o = pre_r[0];
            end
            default: begin
               // ROR: carry is the bit that wraps into the MSB.
               val_o   = (val_i >> kk) | (val_i << (WIDTH - kk));
               carry_o = pre_r[0];
            end
         endcase
      end
   end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle ARM shifter operand unit (LSL/LSR/ASR/ROR/RRX/bypass).
// Ports: in_* request handshake, out_* result handshake, result/carry_out.
module shift_unit_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = 8,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [1:0]       sh,
   input  logic [AMT_W-1:0] amount,
   input  logic             rrx,
   input  logic             bypass,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   localparam int RW = clog2(WIDTH + 1);
   localparam int KW = clog2(STEP + 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic             carry_q, carry_d;
   logic [RW-1:0]    rem_q, rem_d;
   logic [1:0]       sh_q, sh_d;
   logic             over_q, over_d;

   logic [KW-1:0]    k;
   logic [WIDTH-1:0] step_val;
   logic             step_c;
   int               amt;
   int               neff;

   assign k = (rem_q > RW'(STEP)) ? KW'(STEP) : rem_q[KW-1:0];

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .KW    (KW)
   ) u_step (
      .val_i   (val_q),
      .k_i     (k),
      .sh_i    (sh_q),
      .carry_i (carry_q),
      .val_o   (step_val),
      .carry_o (step_c)
   );

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      carry_d = carry_q;
      rem_d   = rem_q;
      sh_d    = sh_q;
      over_d  = over_q;
      amt     = int'(amount);
      neff    = 0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               val_d   = data_in;
               carry_d = carry_in;
               sh_d    = sh;
               over_d  = 1'b0;
               if (bypass) begin
                  neff = 0;
               end else if (sh == SH_ROR && rrx) begin
                  val_d   = {carry_in, data_in[WIDTH-1:1]};
                  carry_d = data_in[0];
               end else if (amt == 0) begin
                  neff = 0;
               end else if (sh == SH_ROR) begin
                  neff = amt % WIDTH;
                  // Whole rotations leave data intact, carry = MSB.
                  if (neff == 0) carry_d = data_in[WIDTH-1];
               end else begin
                  neff   = (amt > WIDTH) ? WIDTH : amt;
                  over_d = (amt > WIDTH) && (sh != SH_ASR);
               end
               rem_d   = RW'(neff);
               state_d = (neff == 0) ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            val_d   = step_val;
            carry_d = step_c;
            rem_d   = rem_q - RW'(k);
            if (rem_d == '0) begin
               state_d = ST_DONE;
               if (over_q) begin
                  val_d   = '0;
                  carry_d = 1'b0;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         val_q   <= '0;
         carry_q <= 1'b0;
         rem_q   <= '0;
         sh_q    <= SH_LSL;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         carry_q <= carry_d;
         rem_q   <= rem_d;
         sh_q    <= sh_d;
         over_q  <= over_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = val_q;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq with a spec-level reference model.
// Checks result/carry every DONE cycle, plus latency and handshakes.
module tb_shift_unit_seq;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic [1:0]  sh;
   logic [7:0]  amount;
   logic        rrx;
   logic        bypass;
   logic        carry_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        carry_out;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_res;
   logic        exp_c;
   bit          chk_en = 0;

   logic [31:0] gr;
   logic        gc;
   int          gl;

   shift_unit_seq #(
      .WIDTH (32),
      .AMT_W (8),
      .STEP  (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .sh        (sh),
      .amount    (amount),
      .rrx       (rrx),
      .bypass    (bypass),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chk_en && out_valid) begin
         checks++;
         if (result !== exp_res || carry_out !== exp_c) begin
            errors++;
            $display("FAIL done_out: got %h/%b required %h/%b",
                     result, carry_out, exp_res, exp_c);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Reference: ARM shifter operand rules, computed in one shot.
   task automatic model(input logic [31:0] d, input logic [1:0] s,
                        input logic [7:0] a8, input logic r, input logic b,
                        input logic ci, output logic [31:0] res,
                        output logic c, output int lat);
      logic [63:0]        t;
      logic signed [63:0] ts;
      int a;
      int n;
      a = int'(a8);
      n = 0;
      res = d;
      c = ci;
      if (b) begin
         n = 0;
      end else if (s == 2'b11 && r) begin
         res = {ci, d[31:1]};
         c = d[0];
      end else if (a == 0) begin
         n = 0;
      end else if (s == 2'b00 || s == 2'b01) begin
         n = (a > 32) ? 32 : a;
         if (s == 2'b00) begin
            t = {32'b0, d} << n;
            res = t[31:0];
            c = t[32];
         end else begin
            t = {d, 32'b0} >> n;
            res = t[63:32];
            c = t[31];
         end
         if (a > 32) begin
            res = '0;
            c = 1'b0;
         end
      end else if (s == 2'b10) begin
         n = (a > 32) ? 32 : a;
         ts = {d, 32'b0};
         ts = ts >>> n;
         res = ts[63:32];
         c = ts[31];
      end else begin
         n = a % 32;
         t = {d, d} >> n;
         res = t[31:0];
         c = res[31];
      end
      lat = 1 + (n + 3) / 4;
   endtask

   task automatic run(input logic [31:0] d, input logic [1:0] s,
                      input logic [7:0] a, input logic r, input logic b,
                      input logic ci, input int hold,
                      output logic [31:0] o_r, output logic o_c,
                      output int lat);
      logic [31:0] mr;
      logic        mc;
      int          ml;
      bit          seen;
      model(d, s, a, r, b, ci, mr, mc, ml);
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      data_in  = d;
      sh       = s;
      amount   = a;
      rrx      = r;
      bypass   = b;
      carry_in = ci;
      in_valid = 1'b1;
      exp_res  = mr;
      exp_c    = mc;
      chk_en   = 1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat  = 1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         lat++;
      end
      o_r = result;
      o_c = carry_out;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout: out_valid not seen, required latency %0d", ml);
         return;
      end
      chk("latency", lat, ml);
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic lit(input string name, input logic [31:0] er,
                      input logic ec, input int el);
      chk({name, "_res"}, gr, er);
      chk({name, "_carry"}, gc, ec);
      chk({name, "_lat"}, gl, el);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      sh        = 2'b00;
      amount    = '0;
      rrx       = 1'b0;
      bypass    = 1'b0;
      carry_in  = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;

      run(32'h8000_0001, 2'b00, 8'd1, 0, 0, 0, 0, gr, gc, gl);
      lit("lsl1", 32'h0000_0002, 1'b1, 2);
      run(32'h8000_0001, 2'b00, 8'd0, 0, 0, 1, 0, gr, gc, gl);
      lit("lsl0", 32'h8000_0001, 1'b1, 1);
      run(32'h8000_0000, 2'b01, 8'd32, 0, 0, 0, 0, gr, gc, gl);
      lit("lsr32", 32'h0, 1'b1, 9);
      run(32'h8000_0000, 2'b01, 8'd33, 0, 0, 1, 0, gr, gc, gl);
      lit("lsr33", 32'h0, 1'b0, 9);
      run(32'h8000_0000, 2'b10, 8'd40, 0, 0, 0, 0, gr, gc, gl);
      lit("asr40", 32'hFFFF_FFFF, 1'b1, 9);
      run(32'h0000_00F1, 2'b11, 8'd4, 0, 0, 1, 0, gr, gc, gl);
      lit("ror4", 32'h1000_000F, 1'b0, 2);
      run(32'h0000_00F1, 2'b11, 8'd36, 0, 0, 1, 0, gr, gc, gl);
      lit("ror36", 32'h1000_000F, 1'b0, 2);
      run(32'h0000_00F1, 2'b11, 8'd32, 0, 0, 1, 0, gr, gc, gl);
      lit("ror32", 32'h0000_00F1, 1'b0, 1);
      run(32'h0000_0003, 2'b11, 8'd9, 1, 0, 1, 0, gr, gc, gl);
      lit("rrx", 32'h8000_0001, 1'b1, 1);
      run(32'h1234_5678, 2'b10, 8'd5, 0, 1, 1, 0, gr, gc, gl);
      lit("bypass", 32'h1234_5678, 1'b1, 1);

      run(32'hFFFF_FFFF, 2'b00, 8'd31, 0, 0, 0, 0, gr, gc, gl);
      run(32'h1234_5680, 2'b01, 8'd7, 0, 0, 0, 0, gr, gc, gl);
      run(32'h8000_0010, 2'b10, 8'd5, 0, 0, 0, 0, gr, gc, gl);
      run(32'hDEAD_BEEF, 2'b11, 8'd13, 0, 0, 0, 0, gr, gc, gl);
      run(32'h7FFF_FFFF, 2'b10, 8'd32, 0, 0, 1, 0, gr, gc, gl);
      run(32'h0000_0001, 2'b00, 8'd32, 0, 0, 0, 0, gr, gc, gl);
      run(32'hFFFF_FFFF, 2'b00, 8'd255, 0, 0, 1, 0, gr, gc, gl);

      run(32'h0000_F000, 2'b01, 8'd13, 0, 0, 0, 5, gr, gc, gl);
      lit("bp_lsr13", 32'h0000_0007, 1'b1, 5);
      run(32'h8000_0000, 2'b10, 8'd3, 0, 0, 0, 0, gr, gc, gl);
      lit("b2b_asr3", 32'hF000_0000, 1'b0, 2);

      @(negedge clk);
      chk_en   = 0;
      data_in  = 32'h0000_FFFF;
      sh       = 2'b00;
      amount   = 8'd20;
      rrx      = 1'b0;
      bypass   = 1'b0;
      carry_in = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("busy_result_nz", {31'b0, result != 0}, 1);
      reset = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_result", result, 0);
      chk("arst_carry", carry_out, 0);
      chk("arst_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      run(32'h0000_0001, 2'b00, 8'd3, 0, 0, 0, 0, gr, gc, gl);
      lit("post_rst_lsl3", 32'h0000_0008, 1'b0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Parametrised multi-cycle successor to the datapath barrel shifter. Implements ARM shifter-operand semantics: LSL/LSR/ASR/ROR, RRX and bypass, with carry-out, for register-specified amounts up to 2^AMT_W-1. Shifts iteratively, up to STEP positions per cycle, behind valid/ready handshakes. Sits between the register-file read port and the ALU B operand in the multi-cycle datapath.

Parameters:
WIDTH, 32, operand width; power of two, at least 8.
AMT_W, 8, shift-amount width (ARM Rs[7:0]).
STEP, 4, max positions shifted per cycle; power of two, 1..WIDTH.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  high only in IDLE.
data_in  in  WIDTH  operand.
sh  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
amount  in  AMT_W  shift amount.
rrx  in  1  with sh=11, selects RRX; amount is ignored.
bypass  in  1  pass-through; overrides sh and rrx.
carry_in  in  1  current C flag.
out_valid  out  1  result valid; held until out_ready.
out_ready  in  1  consumer accepts.
result  out  WIDTH  shifted value.
carry_out  out  1  shifter carry.

Behaviour:
- Reset (async): state=IDLE; result=0; carry_out=0; out_valid=0; internal remaining count=0. Reset mid-BUSY or mid-DONE discards the operation.
- States:
  - IDLE: in_ready=1. On in_valid, latch operands and compute n_eff.
    - n_eff=0 -> DONE.
    - otherwise -> BUSY.
  - BUSY: each cycle, k=min(remaining, STEP).
    - Shift the working register by k.
    - carry_out = last bit shifted out (ROR: new MSB).
    - remaining -= k.
    - remaining reaches 0 -> DONE.
  - DONE: out_valid=1; result and carry_out stable. out_ready -> IDLE. No new request is accepted in DONE.
- Latency: out_valid rises 1+ceil(n_eff/STEP) edges after the accept edge.
- Loading rules at accept:
  - bypass: result=data, carry=carry_in, n_eff=0.
  - RRX: result={carry_in, data[W-1:1]}, carry=data[0], n_eff=0.
  - amount=0, any sh: result=data, carry=carry_in.
  - LSL/LSR: n_eff=min(amount, WIDTH); flag over=(amount>WIDTH).
    - amount=WIDTH: result 0; carry data[0] (LSL) or data[W-1] (LSR).
    - over=1: result 0 and carry 0, forced when entering DONE.
  - ASR: n_eff=min(amount, WIDTH). amount>=WIDTH gives all-sign result, carry = sign.
  - ROR: n_eff=amount mod WIDTH.
    - amount!=0 and n_eff=0: result=data, carry=data[W-1].
- Width rules: all shifts are WIDTH-bit; ASR fill = data[W-1]; ROR wraps bit 0 into bit W-1.
- in_valid during BUSY/DONE is ignored (in_ready=0); upstream holds the request.

Decomposition:
- Package shift_pkg:
  - SH_LSL/SH_LSR/SH_ASR/SH_ROR encodings.
  - State encodings ST_IDLE/ST_BUSY/ST_DONE.
  - Helper function clog2 for the remaining-count width, clog2(WIDTH+1).
- Sub-module shift_step: combinational single step.
  - Inputs: value, k (0..STEP), sh, carry.
  - Outputs: shifted value and carry.
  - Instantiated once in shift_unit_seq.

Test Plan:
(All with WIDTH=32, STEP=4.)
1. LSL data=0x8000_0001, amount=1, carry_in=0 -> result 0x0000_0002, carry_out=1, out_valid 2 edges after accept. amount=0, carry_in=1 -> result=data, carry 1, latency 1.
2. LSR 0x8000_0000: amount=32 -> 0, carry 1, latency 9. amount=33 -> 0, carry 0. ASR amount=40 -> 0xFFFF_FFFF, carry 1, latency 9.
3. ROR 0x0000_00F1: amount=4 -> 0x1000_000F, carry 0, latency 2. amount=36 -> same result/latency. amount=32 -> 0x0000_00F1, carry 0, latency 1.
4. RRX data=0x0000_0003, carry_in=1 -> 0x8000_0001, carry 1, latency 1. bypass with sh=10, amount=5 -> data unchanged, carry=carry_in.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> result, carry_out, out_valid stable and in_ready=0; raise out_ready -> IDLE next edge; back-to-back request accepted the following cycle.
6. Assert reset during BUSY of LSL amount=20 -> out_valid=0, result=0, carry_out=0 immediately (async). After release, in_ready=1 and a new LSL amount=3 of 0x1 -> 0x8.
